// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller serving IDCODE/USERCODE/BYPASS and forwarding DEBUG to the debug unit.
// Define JTAG_USERCODE_EN to give opcode 0011 the 32-bit USERCODE register; otherwise it decodes as BYPASS.
module jtag_tap_controller #(
   parameter              TECHNOLOGY    = "Generic",
   parameter logic [31:0] JTAG_IDCODE   = 32'h0000_0001,
   parameter logic [31:0] JTAG_USERCODE = 32'h0
) (
   input  logic jtag_tck,
   input  logic jtag_trst,
   input  logic jtag_tms,
   input  logic jtag_tdi,
   output logic jtag_tdo,
   output logic jtag_tdo_oe,
   output logic tap_tck,
   output logic tap_TestLogicReset,
   output logic tap_CaptureDR,
   output logic tap_ShiftDR,
   output logic tap_PauseDR,
   output logic tap_UpdateDR,
   output logic dbg_sel,
   output logic dbg_tdi,
   input  logic dbg_tdo
);

   typedef enum logic [3:0] {
      ST_TLR, ST_RTI,
      ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR, ST_UPD_DR,
      ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
   } tap_state_t;

   localparam logic [3:0] IR_IDCODE   = 4'b0010;
   localparam logic [3:0] IR_USERCODE = 4'b0011;
   localparam logic [3:0] IR_DEBUG    = 4'b1000;

   tap_state_t  state, next_state;
   logic [3:0]  ir_shift;
   logic [3:0]  ir_latched;
   logic [31:0] dr_shift;
   logic        bypass_reg;
   logic        sel_idcode, sel_usercode, sel_bypass;

   always_ff @(posedge jtag_tck) begin
      if (jtag_trst) state <= ST_TLR;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_TLR:    next_state = jtag_tms ? ST_TLR    : ST_RTI;
         ST_RTI:    next_state = jtag_tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_DR: next_state = jtag_tms ? ST_SEL_IR : ST_CAP_DR;
         ST_CAP_DR: next_state = jtag_tms ? ST_EX1_DR : ST_SH_DR;
         ST_SH_DR:  next_state = jtag_tms ? ST_EX1_DR : ST_SH_DR;
         ST_EX1_DR: next_state = jtag_tms ? ST_UPD_DR : ST_PAU_DR;
         ST_PAU_DR: next_state = jtag_tms ? ST_EX2_DR : ST_PAU_DR;
         ST_EX2_DR: next_state = jtag_tms ? ST_UPD_DR : ST_SH_DR;
         ST_UPD_DR: next_state = jtag_tms ? ST_SEL_DR : ST_RTI;
         ST_SEL_IR: next_state = jtag_tms ? ST_TLR    : ST_CAP_IR;
         ST_CAP_IR: next_state = jtag_tms ? ST_EX1_IR : ST_SH_IR;
         ST_SH_IR:  next_state = jtag_tms ? ST_EX1_IR : ST_SH_IR;
         ST_EX1_IR: next_state = jtag_tms ? ST_UPD_IR : ST_PAU_IR;
         ST_PAU_IR: next_state = jtag_tms ? ST_EX2_IR : ST_PAU_IR;
         ST_EX2_IR: next_state = jtag_tms ? ST_UPD_IR : ST_SH_IR;
         ST_UPD_IR: next_state = jtag_tms ? ST_SEL_DR : ST_RTI;
         default:   next_state = ST_TLR;
      endcase
   end

   assign sel_idcode = (ir_latched == IR_IDCODE);
   assign dbg_sel    = (ir_latched == IR_DEBUG);
`ifdef JTAG_USERCODE_EN
   assign sel_usercode = (ir_latched == IR_USERCODE);
`else
   assign sel_usercode = 1'b0;
`endif
   assign sel_bypass = !(sel_idcode || sel_usercode || dbg_sel);

   // The latched IR is also cleared on the way into TLR so a DEBUG selection drops as soon as TLR is reached.
   always_ff @(posedge jtag_tck) begin
      if (jtag_trst) begin
         ir_shift   <= 4'b0000;
         ir_latched <= IR_IDCODE;
         dr_shift   <= 32'h0;
         bypass_reg <= 1'b0;
      end else begin
         if (state == ST_CAP_IR)     ir_shift <= 4'b0101;
         else if (state == ST_SH_IR) ir_shift <= {jtag_tdi, ir_shift[3:1]};

         if (state == ST_TLR || next_state == ST_TLR) ir_latched <= IR_IDCODE;
         else if (state == ST_UPD_IR)                 ir_latched <= ir_shift;

         if (state == ST_CAP_DR) begin
            if (sel_idcode) dr_shift <= JTAG_IDCODE;
`ifdef JTAG_USERCODE_EN
            if (sel_usercode) dr_shift <= JTAG_USERCODE;
`endif
            if (sel_bypass) bypass_reg <= 1'b0;
         end else if (state == ST_SH_DR) begin
            if (sel_idcode || sel_usercode) dr_shift <= {jtag_tdi, dr_shift[31:1]};
            if (sel_bypass) bypass_reg <= jtag_tdi;
         end
      end
   end

   always_comb begin
      jtag_tdo = 1'b0;
      if (state == ST_SH_IR) begin
         jtag_tdo = ir_shift[0];
      end else if (state == ST_SH_DR) begin
         if (dbg_sel)                         jtag_tdo = dbg_tdo;
         else if (sel_idcode || sel_usercode) jtag_tdo = dr_shift[0];
         else                                 jtag_tdo = bypass_reg;
      end
   end

   assign jtag_tdo_oe        = (state == ST_SH_DR) || (state == ST_SH_IR);
   assign tap_tck            = jtag_tck;
   assign dbg_tdi            = jtag_tdi;
   assign tap_TestLogicReset = (state == ST_TLR);
   assign tap_CaptureDR      = (state == ST_CAP_DR);
   assign tap_ShiftDR        = (state == ST_SH_DR);
   assign tap_PauseDR        = (state == ST_PAU_DR);
   assign tap_UpdateDR       = (state == ST_UPD_DR);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed testbench for jtag_tap_controller: reset, IDCODE, BYPASS, IR capture, DEBUG forwarding,
// TLR escape, mid-shift reset and USERCODE (expectation follows JTAG_USERCODE_EN).
module tb_jtag_tap_controller;

   logic jtag_tck, jtag_trst, jtag_tms, jtag_tdi, dbg_tdo;
   logic jtag_tdo, jtag_tdo_oe, tap_tck, tap_TestLogicReset;
   logic tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR, dbg_sel, dbg_tdi;

   int n_compared   = 0;
   int n_mismatched = 0;

   localparam logic [31:0] IDCODE_VAL   = 32'h1495_11C3;
   localparam logic [31:0] USERCODE_VAL = 32'hDEAD_BEEF;

   jtag_tap_controller #(
      .TECHNOLOGY    ("Generic"),
      .JTAG_IDCODE   (IDCODE_VAL),
      .JTAG_USERCODE (USERCODE_VAL)
   ) dut (
      .jtag_tck           (jtag_tck),
      .jtag_trst          (jtag_trst),
      .jtag_tms           (jtag_tms),
      .jtag_tdi           (jtag_tdi),
      .jtag_tdo           (jtag_tdo),
      .jtag_tdo_oe        (jtag_tdo_oe),
      .tap_tck            (tap_tck),
      .tap_TestLogicReset (tap_TestLogicReset),
      .tap_CaptureDR      (tap_CaptureDR),
      .tap_ShiftDR        (tap_ShiftDR),
      .tap_PauseDR        (tap_PauseDR),
      .tap_UpdateDR       (tap_UpdateDR),
      .dbg_sel            (dbg_sel),
      .dbg_tdi            (dbg_tdi),
      .dbg_tdo            (dbg_tdo)
   );

   initial jtag_tck = 1'b0;
   always #5 jtag_tck = ~jtag_tck;

   // Inputs change 1 time unit after each rising edge, which is also when outputs are sampled.
   task automatic step(input logic tms, input logic tdi);
      jtag_tms = tms;
      jtag_tdi = tdi;
      @(posedge jtag_tck);
      #1;
   endtask

   // From RTI: walk to ShDR, shift n bits LSB first, exit through UpdDR back to RTI.
   task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout, output int oe_bad);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      dout   = 32'h0;
      oe_bad = 0;
      for (int i = 0; i < n; i++) begin
         dout[i] = jtag_tdo;
         if (jtag_tdo_oe !== 1'b1) oe_bad++;
         step(i == n - 1, din[i]);
      end
      if (jtag_tdo_oe !== 1'b0) oe_bad++;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   // From RTI: load a 4-bit opcode into the IR and return to RTI.
   task automatic load_ir(input logic [3:0] op);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(i == 3, op[i]);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      logic [6:0] got;
      jtag_trst = 1'b1;
      step(1'b0, 1'b0);
      jtag_trst = 1'b0;
      got = {tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR, dbg_sel, jtag_tdo_oe};
      n_compared++;
      if (got !== 7'b1000000) begin
         n_mismatched++;
         $display("[TB] FAIL reset_outputs got=%b want=%b", got, 7'b1000000);
      end
      n_compared++;
      if (jtag_tdo !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_tdo got=%b want=0", jtag_tdo);
      end
      step(1'b0, 1'b0);
      n_compared++;
      if (tap_TestLogicReset !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL rti_tlr_low got=%b want=0", tap_TestLogicReset);
      end
   endtask

   task automatic test_idcode();
      logic [31:0] d;
      int          bad;
      shift_dr(32, 32'h0, d, bad);
      n_compared++;
      if (d !== IDCODE_VAL) begin
         n_mismatched++;
         $display("[TB] FAIL idcode_read got=%h want=%h", d, IDCODE_VAL);
      end
      n_compared++;
      if (bad !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL idcode_oe bad_cycles=%0d want=0", bad);
      end
   endtask

   task automatic test_bypass();
      logic [31:0] d;
      int          bad;
      load_ir(4'b1111);
      shift_dr(9, 32'h0000_00A5, d, bad);
      n_compared++;
      if (d[8:0] !== 9'h14A) begin
         n_mismatched++;
         $display("[TB] FAIL bypass_delay got=%h want=%h", d[8:0], 9'h14A);
      end
      n_compared++;
      if (bad !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL bypass_oe bad_cycles=%0d want=0", bad);
      end
   endtask

   task automatic test_ir_capture();
      logic [3:0] got;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      n_compared++;
      if (jtag_tdo_oe !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL shir_oe got=%b want=1", jtag_tdo_oe);
      end
      for (int i = 0; i < 4; i++) begin
         got[i] = jtag_tdo;
         step(i == 3, 1'b1);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_compared++;
      if (got !== 4'b0101) begin
         n_mismatched++;
         $display("[TB] FAIL ir_capture got=%b want=0101", got);
      end
   endtask

   task automatic test_debug();
      load_ir(4'b1000);
      n_compared++;
      if (dbg_sel !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL debug_sel got=%b want=1", dbg_sel);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_compared++;
      if ({tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR} !== 4'b1000) begin
         n_mismatched++;
         $display("[TB] FAIL capdr_strobes got=%b want=1000", {tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR});
      end
      step(1'b0, 1'b1);
      n_compared++;
      if ({tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR} !== 4'b0100) begin
         n_mismatched++;
         $display("[TB] FAIL shdr_strobes got=%b want=0100", {tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR});
      end
      n_compared++;
      if (dbg_tdi !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL dbg_tdi got=%b want=1", dbg_tdi);
      end
      dbg_tdo = 1'b1;
      #1;
      n_compared++;
      if (jtag_tdo !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL dbg_tdo_hi got=%b want=1", jtag_tdo);
      end
      dbg_tdo = 1'b0;
      #1;
      n_compared++;
      if (jtag_tdo !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL dbg_tdo_lo got=%b want=0", jtag_tdo);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_compared++;
      if ({tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR} !== 4'b0010) begin
         n_mismatched++;
         $display("[TB] FAIL paudr_strobes got=%b want=0010", {tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR});
      end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      n_compared++;
      if ({tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR} !== 4'b0001) begin
         n_mismatched++;
         $display("[TB] FAIL upddr_strobes got=%b want=0001", {tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR});
      end
      step(1'b0, 1'b0);
      n_compared++;
      if ({tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR, dbg_sel} !== 5'b00001) begin
         n_mismatched++;
         $display("[TB] FAIL rti_after_debug got=%b want=00001", {tap_CaptureDR, tap_ShiftDR, tap_PauseDR, tap_UpdateDR, dbg_sel});
      end
   endtask

   task automatic test_tlr_escape();
      logic [31:0] d;
      int          bad;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      n_compared++;
      if (tap_TestLogicReset !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL escape_from_shdr got=%b want=1", tap_TestLogicReset);
      end
      step(1'b0, 1'b0);
      n_compared++;
      if (dbg_sel !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL escape_dbg_sel got=%b want=0", dbg_sel);
      end
      shift_dr(32, 32'hFFFF_FFFF, d, bad);
      n_compared++;
      if (d !== IDCODE_VAL) begin
         n_mismatched++;
         $display("[TB] FAIL escape_ir_idcode got=%h want=%h", d, IDCODE_VAL);
      end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      n_compared++;
      if (tap_TestLogicReset !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL escape_from_shir got=%b want=1", tap_TestLogicReset);
      end
      step(1'b0, 1'b0);
      shift_dr(32, 32'h0, d, bad);
      n_compared++;
      if (d !== IDCODE_VAL) begin
         n_mismatched++;
         $display("[TB] FAIL partial_ir_discard got=%h want=%h", d, IDCODE_VAL);
      end
   endtask

   task automatic test_trst_mid_shift();
      load_ir(4'b1000);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      jtag_trst = 1'b1;
      step(1'b0, 1'b1);
      jtag_trst = 1'b0;
      n_compared++;
      if ({tap_TestLogicReset, dbg_sel, jtag_tdo_oe, jtag_tdo} !== 4'b1000) begin
         n_mismatched++;
         $display("[TB] FAIL trst_mid_shir got=%b want=1000", {tap_TestLogicReset, dbg_sel, jtag_tdo_oe, jtag_tdo});
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_usercode();
      logic [31:0] d;
      logic [31:0] want;
      int          bad;
`ifdef JTAG_USERCODE_EN
      want = USERCODE_VAL;
`else
      want = 32'h2468_ACF0;
`endif
      load_ir(4'b0011);
      shift_dr(32, 32'h1234_5678, d, bad);
      n_compared++;
      if (d !== want) begin
         n_mismatched++;
         $display("[TB] FAIL usercode_read got=%h want=%h", d, want);
      end
   endtask

   initial begin
      jtag_trst = 1'b0;
      jtag_tms  = 1'b1;
      jtag_tdi  = 1'b0;
      dbg_tdo   = 1'b0;
      test_reset();
      test_idcode();
      test_bypass();
      test_ir_capture();
      test_debug();
      test_tlr_escape();
      test_trst_mid_shift();
      test_usercode();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
